// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 binary-code-modulation panel driver.
//   - scan FSM state encoding
//   - CTRL register field positions and reset display time
//   - ctrl_word(): packs the CTRL fields into the 32-bit bus view
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_WAIT,
    ST_LATCH
  } scan_state_t;

  localparam int CTRL_BUF_BIT   = 0;
  localparam int CTRL_VSYNC_BIT = 8;
  localparam int CTRL_T_LSB     = 16;
  localparam int CTRL_T_W       = 8;

  localparam logic [CTRL_T_W-1:0] DEFAULT_T = 8'd8;

  function automatic logic [31:0] ctrl_word(input logic buf_req, input logic vsync,
                                            input logic [CTRL_T_W-1:0] t_base);
    ctrl_word = '0;
    ctrl_word[CTRL_BUF_BIT]                        = buf_req;
    ctrl_word[CTRL_VSYNC_BIT]                      = vsync;
    ctrl_word[CTRL_T_LSB +: CTRL_T_W]              = t_base;
  endfunction

endpackage

// File: rtl/hub75_pixel_ram.sv
// Pixel store for one panel half (both frame buffers).
//   Port A (bus side): byte-masked write, registered read every cycle.
//   Port B (scan side): registered read, updated only when b_re is high so
//   the scan data stays stable while a column is being shifted out.
// Ports: clk; a_addr/a_we/a_wmask/a_wdata/a_rdata; b_addr/b_re/b_rdata.
// Contents are deliberately not reset.
module hub75_pixel_ram #(
  parameter  int DEPTH = 32,
  parameter  int DW    = 12,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = (DW + 7) / 8
) (
  input  logic            clk,
  input  logic [AW-1:0]   a_addr,
  input  logic            a_we,
  input  logic [NB-1:0]   a_wmask,
  input  logic [NB*8-1:0] a_wdata,
  output logic [DW-1:0]   a_rdata,
  input  logic [AW-1:0]   b_addr,
  input  logic            b_re,
  output logic [DW-1:0]   b_rdata
);

  // Stored as whole bytes; bits above DW exist but are never read back.
  logic [NB*8-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_we) begin
      for (int k = 0; k < NB; k++) begin
        if (a_wmask[k]) mem[a_addr][k*8 +: 8] <= a_wdata[k*8 +: 8];
      end
    end
    a_rdata <= mem[a_addr][DW-1:0];
    if (b_re) b_rdata <= mem[b_addr][DW-1:0];
  end

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED panel driver with binary-code-modulated colour depth.
// Bus side: word-addressed register window at BASEADDR; 2*ROWS*COLS pixel
// words (two frame buffers) followed by one CTRL word. Every decoded
// access is answered with ready one cycle later.
// Panel side: for each row pair and each bit plane, COLS columns are shifted
// (3 cycles per column), the shift register is latched, and OE is held low
// for T << plane cycles while the next plane is shifted.
// Ports: clk, rst (sync, active high); addr/wdata/wmask/wen/ren in,
// rdata/ready/active out; R0/G0/B0, R1/G1/B1, ROWSEL, CLK_HUB75, LATCH,
// OE (active low) to the panel. Assumes ROWS >= 4.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter int          ROWS       = 64,
  parameter int          COLS       = 64,
  parameter int          COLOR_BITS = 8,
  parameter logic [31:0] BASEADDR   = 32'h81000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wdata,
  input  logic [3:0]                    wmask,
  input  logic                          wen,
  input  logic                          ren,
  output logic [31:0]                   rdata,
  output logic                          ready,
  output logic                          active,
  output logic                          R0,
  output logic                          G0,
  output logic                          B0,
  output logic                          R1,
  output logic                          G1,
  output logic                          B1,
  output logic [$clog2(ROWS/2)-1:0]     ROWSEL,
  output logic                          CLK_HUB75,
  output logic                          LATCH,
  output logic                          OE
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int RSW   = $clog2(ROWS/2);
  localparam int PW    = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int DW    = 3 * COLOR_BITS;
  localparam int NB    = (DW + 7) / 8;
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int NPIX  = 2 * ROWS * COLS;
  localparam int CNTW  = CTRL_T_W + COLOR_BITS - 1;

  // ---------------- bus decode ----------------
  logic [31:0] off;
  logic [29:0] widx;
  logic        hit_pix, hit_ctrl, half, acc, ctrl_we;
  logic [AW-1:0] bus_ram_addr;

  assign off      = addr - BASEADDR;   // below-base addresses wrap high and miss
  assign widx     = off[31:2];
  assign hit_pix  = widx < 30'(NPIX);
  assign hit_ctrl = widx == 30'(NPIX);
  assign active   = hit_pix | hit_ctrl;
  assign acc      = active & (wen | ren);
  assign ctrl_we  = wen & hit_ctrl;

  // Row MSB picks the half; the rest of the index (buffer, low row bits,
  // column) addresses within that half's RAM.
  assign half         = widx[CW+RW-1];
  assign bus_ram_addr = {widx[CW+RW], widx[CW+RW-2:0]};

  logic unused_bus;
  assign unused_bus = &{1'b0, off[1:0], wdata, wmask};

  // ---------------- CTRL state ----------------
  logic                buf_req, vsync, disp_buf;
  logic [CTRL_T_W-1:0] t_base;
  logic                swap_now;

  // ---------------- scan state ----------------
  scan_state_t      state, state_n;
  logic [CW-1:0]    col;
  logic [PW-1:0]    plane;
  logic [RSW-1:0]   row, rowsel_q;
  logic [CNTW-1:0]  cnt;
  logic             shifting, clk_hi, latch_st, ram_re, last_col;
  logic             scan_buf;

  assign last_col = col == CW'(COLS - 1);
  assign swap_now = (state == ST_FETCH) && (row == '0) && (plane == '0) && (col == '0);
  // The frame-start fetch already reads from the newly selected buffer.
  assign scan_buf = swap_now ? buf_req : disp_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_req  <= 1'b0;
      vsync    <= 1'b0;
      t_base   <= DEFAULT_T;
      disp_buf <= 1'b0;
    end else begin
      if (ctrl_we && wmask[0]) buf_req <= wdata[CTRL_BUF_BIT];
      if (ctrl_we && wmask[2]) t_base  <= wdata[CTRL_T_LSB +: CTRL_T_W];
      // A frame-start set beats a same-cycle bus clear.
      if (swap_now) vsync <= 1'b1;
      else if (ctrl_we && wmask[1] && wdata[CTRL_VSYNC_BIT]) vsync <= 1'b0;
      if (swap_now) disp_buf <= buf_req;
    end
  end

  // ---------------- pixel RAMs ----------------
  logic [DW-1:0] top_a, bot_a, top_q, bot_q;

  hub75_pixel_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram_top (
    .clk     (clk),
    .a_addr  (bus_ram_addr),
    .a_we    (wen & hit_pix & ~half),
    .a_wmask (wmask[NB-1:0]),
    .a_wdata (wdata[NB*8-1:0]),
    .a_rdata (top_a),
    .b_addr  ({scan_buf, row, col}),
    .b_re    (ram_re),
    .b_rdata (top_q)
  );

  hub75_pixel_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram_bot (
    .clk     (clk),
    .a_addr  (bus_ram_addr),
    .a_we    (wen & hit_pix & half),
    .a_wmask (wmask[NB-1:0]),
    .a_wdata (wdata[NB*8-1:0]),
    .a_rdata (bot_a),
    .b_addr  ({scan_buf, row, col}),
    .b_re    (ram_re),
    .b_rdata (bot_q)
  );

  // ---------------- bus response ----------------
  logic        ready_q, rd_q, rd_ctrl_q, rd_half_q;
  logic [31:0] ctrl_snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      rd_q      <= 1'b0;
      rd_ctrl_q <= 1'b0;
      rd_half_q <= 1'b0;
      ctrl_snap <= '0;
    end else begin
      ready_q   <= acc;
      rd_q      <= ren & active;
      rd_ctrl_q <= hit_ctrl;
      rd_half_q <= half;
      ctrl_snap <= ctrl_word(buf_req, vsync, t_base);
    end
  end

  always_comb begin
    rdata = '0;
    if (!rst && rd_q) begin
      if (rd_ctrl_q)      rdata = ctrl_snap;
      else if (rd_half_q) rdata = 32'(bot_a);
      else                rdata = 32'(top_a);
    end
  end
  assign ready = ~rst & ready_q;

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    shifting = 1'b0;
    clk_hi   = 1'b0;
    latch_st = 1'b0;
    ram_re   = 1'b0;
    case (state)
      ST_FETCH: begin
        ram_re  = 1'b1;
        state_n = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        shifting = 1'b1;
        state_n  = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        shifting = 1'b1;
        clk_hi   = 1'b1;
        state_n  = last_col ? ST_WAIT : ST_FETCH;
      end
      ST_WAIT: begin
        if (cnt == '0) state_n = ST_LATCH;
      end
      ST_LATCH: begin
        latch_st = 1'b1;
        state_n  = ST_FETCH;
      end
      default: state_n = ST_FETCH;
    endcase
  end

  // Row/plane stay on the plane being latched until LATCH completes, so the
  // display time and ROWSEL both refer to the just-latched data.
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      plane    <= '0;
      row      <= '0;
      cnt      <= '0;
      rowsel_q <= '0;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (state == ST_SHIFT_HI) col <= col + 1'b1;
      if (state == ST_LATCH) begin
        rowsel_q <= row;
        cnt      <= CNTW'(t_base) << plane;
        if (plane == PW'(COLOR_BITS - 1)) begin
          plane <= '0;
          row   <= row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

  // ---------------- panel outputs ----------------
  logic [COLOR_BITS-1:0] t_r, t_g, t_b, b_r, b_g, b_b;
  assign t_r = top_q[COLOR_BITS-1:0];
  assign t_g = top_q[2*COLOR_BITS-1:COLOR_BITS];
  assign t_b = top_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign b_r = bot_q[COLOR_BITS-1:0];
  assign b_g = bot_q[2*COLOR_BITS-1:COLOR_BITS];
  assign b_b = bot_q[3*COLOR_BITS-1:2*COLOR_BITS];

  logic drive;
  assign drive = ~rst & shifting;

  assign R0        = drive & t_r[plane];
  assign G0        = drive & t_g[plane];
  assign B0        = drive & t_b[plane];
  assign R1        = drive & b_r[plane];
  assign G1        = drive & b_g[plane];
  assign B1        = drive & b_b[plane];
  assign CLK_HUB75 = ~rst & clk_hi;
  assign LATCH     = ~rst & latch_st;
  assign OE        = rst | (cnt == '0);
  assign ROWSEL    = rst ? '0 : rowsel_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
module tb_hub75_bcm_driver;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CB   = 4;
  localparam logic [31:0] BASE   = 32'h81000000;
  localparam logic [31:0] CTRL_A = BASE + 32'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] rdata;
  logic        ready, active;
  logic        R0, G0, B0, R1, G1, B1;
  logic [0:0]  ROWSEL;
  logic        CLK_HUB75, LATCH, OE;

  hub75_bcm_driver #(.ROWS(ROWS), .COLS(COLS), .COLOR_BITS(CB), .BASEADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
    .rdata(rdata), .ready(ready), .active(active),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .ROWSEL(ROWSEL), .CLK_HUB75(CLK_HUB75), .LATCH(LATCH), .OE(OE)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          oe;
  logic [5:0]  seen;
  logic [0:0]  rs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m; wen = 1'b1; ren = 1'b0;
    @(negedge clk);
    check("wr_ready", 32'(ready), 32'd1);
    wen = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; ren = 1'b1; wen = 1'b0;
    @(negedge clk);
    check("rd_ready", 32'(ready), 32'd1);
    check(tag, rdata, exp);
    ren = 1'b0;
  endtask

  // Runs from the current negedge through the next LATCH. Reports cycles with
  // OE low, the OR of all colour lines on CLK_HUB75 high cycles, and ROWSEL
  // on the cycle after LATCH.
  task automatic to_latch(output int oe_low, output logic [5:0] sn, output logic [0:0] rsel);
    bit got;
    oe_low = 0; sn = '0; got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      if (!OE) oe_low++;
      if (CLK_HUB75) sn |= {R0, G0, B0, R1, G1, B1};
      if (LATCH) got = 1'b1;
      @(negedge clk);
    end
    check("latch_seen", 32'(got), 32'd1);
    rsel = ROWSEL;
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_oe", 32'(OE), 32'd1);
    check("rst_latch", 32'(LATCH), 32'd0);
    check("rst_clk", 32'(CLK_HUB75), 32'd0);
    check("rst_colour", 32'({R0, G0, B0, R1, G1, B1}), 32'd0);
    check("rst_rowsel", 32'(ROWSEL), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_oe", 32'(OE), 32'd1);
    check("post_rst_ready", 32'(ready), 32'd0);

    for (int i = 0; i < 2*ROWS*COLS; i++) bus_write(BASE + 32'(4*i), 32'd0, 4'hF);
    bus_read("ctrl_reset_vsync", CTRL_A, 32'h00080100);

    // ---- read/write with byte masks ----
    bus_write(BASE, 32'h00F, 4'hF);
    bus_read("word0_full", BASE, 32'h00F);
    bus_write(BASE, 32'hFFF, 4'b0001);
    bus_read("word0_mask", BASE, 32'h0FF);
    bus_write(BASE + 32'h4, 32'hFFFFFFFF, 4'hF);
    bus_read("word1_upper0", BASE + 32'h4, 32'h00000FFF);
    bus_write(BASE + 32'h4, 32'd0, 4'hF);
    bus_write(BASE + 32'h20, 32'hABC, 4'hF);
    bus_read("word8_bottom", BASE + 32'h20, 32'hABC);
    bus_write(BASE + 32'h20, 32'd0, 4'hF);
    bus_write(BASE, 32'h005, 4'hF);

    // ---- BCM timing, T = 1; clear at frame start loses to the set ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_write(CTRL_A, 32'h00010100, 4'b0110);
    to_latch(oe, seen, rs);
    check("p0_seen", 32'(seen), 32'b100000);
    check("p0_oe", 32'(oe), 32'd0);
    check("p0_rowsel", 32'(rs), 32'd0);
    to_latch(oe, seen, rs);
    check("p1_oe", 32'(oe), 32'd1);
    check("p1_seen", 32'(seen), 32'd0);
    to_latch(oe, seen, rs);
    check("p2_oe", 32'(oe), 32'd2);
    check("p2_seen", 32'(seen), 32'b100000);
    to_latch(oe, seen, rs);
    check("p3_oe", 32'(oe), 32'd4);
    check("p3_seen", 32'(seen), 32'd0);
    to_latch(oe, seen, rs);
    check("r1p0_oe", 32'(oe), 32'd8);
    check("r1p0_seen", 32'(seen), 32'd0);
    check("r1p0_rowsel", 32'(rs), 32'd1);
    bus_read("vsync_set_wins", CTRL_A, 32'h00010100);

    // ---- buffer swap mid-frame ----
    bus_write(BASE + 32'h60, 32'h00F, 4'hF);
    bus_write(CTRL_A, 32'h1, 4'b0001);
    bus_write(CTRL_A, 32'h100, 4'b0010);
    bus_read("ctrl_buf_req", CTRL_A, 32'h00010001);
    for (int k = 0; k < 3; k++) begin
      to_latch(oe, seen, rs);
      check("swap_pending_seen", 32'(seen), 32'd0);
    end
    to_latch(oe, seen, rs);
    check("swap_done_seen", 32'(seen), 32'b000100);
    check("swap_done_rowsel", 32'(rs), 32'd0);
    bus_read("vsync_after_swap", CTRL_A, 32'h00010101);
    bus_write(CTRL_A, 32'h100, 4'b0010);
    bus_read("vsync_cleared", CTRL_A, 32'h00010001);

    // ---- T = 0: blanked, latch still pulses 8 times per frame ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_write(CTRL_A, 32'h0, 4'b0100);
    for (int k = 0; k < 9; k++) begin
      to_latch(oe, seen, rs);
      check("t0_oe", 32'(oe), 32'd0);
      if (k == 4) check("t0_rowsel_r1", 32'(rs), 32'd1);
      if (k == 8) check("t0_rowsel_wrap", 32'(rs), 32'd0);
    end

    // ---- reset during plane 2 of row 1 ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_write(CTRL_A, 32'h00010000, 4'b0100);
    for (int k = 0; k < 6; k++) to_latch(oe, seen, rs);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_oe", 32'(OE), 32'd1);
    check("midrst_latch", 32'(LATCH), 32'd0);
    check("midrst_rowsel", 32'(ROWSEL), 32'd0);
    rst = 1'b0;
    bus_write(CTRL_A, 32'h00010000, 4'b0100);
    to_latch(oe, seen, rs);
    check("midrst_p0_seen", 32'(seen), 32'b100000);
    check("midrst_p0_rowsel", 32'(rs), 32'd0);
    to_latch(oe, seen, rs);
    check("midrst_p0_oe", 32'(oe), 32'd1);
    check("midrst_p1_seen", 32'(seen), 32'd0);

    // ---- address decode boundaries ----
    addr = BASE + 32'h84; ren = 1'b1;
    #1 check("dec_past_ctrl_active", 32'(active), 32'd0);
    @(negedge clk);
    check("dec_past_ctrl_ready_rd", 32'(ready), 32'd0);
    ren = 1'b0; wen = 1'b1; wdata = 32'hFFFFFFFF; wmask = 4'hF;
    @(negedge clk);
    check("dec_past_ctrl_ready_wr", 32'(ready), 32'd0);
    wen = 1'b0;
    addr = BASE - 32'h4;
    #1 check("dec_below_base", 32'(active), 32'd0);
    addr = CTRL_A;
    #1 check("dec_ctrl", 32'(active), 32'd1);
    addr = BASE + 32'h7C;
    #1 check("dec_last_pixel", 32'(active), 32'd1);
    @(negedge clk);
    bus_read("ctrl_unchanged", CTRL_A, 32'h00010000 | (32'(dut.vsync) << 8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
